// File: rtl/pipe_stage_skid_if.sv
// pipe_stage_skid_if: valid/ready handshake bundle between a producer, a skid stage and a consumer
interface pipe_stage_skid_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_ready;
    logic             flush;
    logic [1:0]       occupancy;

    modport master (
        output in_valid, in_data, out_ready, flush,
        input  in_ready, out_valid, out_data, occupancy
    );

    modport slave (
        input  in_valid, in_data, out_ready, flush,
        output in_ready, out_valid, out_data, occupancy
    );
endinterface

// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: pipeline stage register with 2-entry skid buffer, flush and NOP bubbles
module pipe_stage_skid #(
    parameter int               WIDTH = 16,
    parameter logic [WIDTH-1:0] NOP   = WIDTH'(16'h0800)
) (
    input logic              clk,
    input logic              rst,
    pipe_stage_skid_if.slave bus
);
    localparam logic [1:0] EMPTY = 2'd0;
    localparam logic [1:0] ONE   = 2'd1;
    localparam logic [1:0] FULL  = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] main_q, main_d;
    logic [WIDTH-1:0] skid_q, skid_d;
    logic             push, pop;

    // Ready and valid come straight from the state flop, so neither out_ready nor flush reaches in_ready
    assign bus.in_ready  = state_q != FULL;
    assign bus.out_valid = state_q != EMPTY;
    assign bus.out_data  = bus.out_valid ? main_q : NOP;
    assign bus.occupancy = state_q;
    assign push          = bus.in_valid & bus.in_ready;
    assign pop           = bus.out_valid & bus.out_ready;

    // Next-state and data steering; flush empties the stage but lets a same-cycle pop complete
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        case (state_q)
            EMPTY: begin
                state_d = push ? ONE : EMPTY;
                main_d  = push ? bus.in_data : main_q;
            end
            ONE: begin
                state_d = (push & !pop) ? FULL : (!push & pop) ? EMPTY : ONE;
                main_d  = (push & pop) ? bus.in_data : main_q;
                skid_d  = (push & !pop) ? bus.in_data : skid_q;
            end
            FULL: begin
                state_d = pop ? ONE : FULL;
                main_d  = pop ? skid_q : main_q;
            end
            default: state_d = EMPTY;
        endcase
        if (bus.flush) state_d = EMPTY;
    end

    // State and payload registers, cleared asynchronously by the active-low reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= EMPTY;
            main_q  <= NOP;
            skid_q  <= NOP;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end
endmodule
